axi_slave_mem: RTL and testbench
================================

# axi_slave_mem

AXI3 responder (slave) with an internal word-organised 32-bit memory; it answers the write (AW/W/B) and read (AR/R) channels driven by an AXI master or testbench. It is the memory-side endpoint of the team's AXI bus and the default DUT for the AXI bench. Write and read paths are independent state machines with one outstanding transaction each. Supported burst types are FIXED, INCR and WRAP, with up to 16 beats.

## Interface
- ID_WIDTH, 4: width of awid/wid/bid/arid/rid.
- ADDR_WIDTH, 32: byte address width.
- MEM_WORDS, 1024: memory depth in 32-bit words; power of two.
- clk  in  1: single clock; all logic rising-edge.
- resetn  in  1: asynchronous, active-low reset.
- awvalid/awready  in/out  1; awid in ID_WIDTH; awaddr in ADDR_WIDTH; awlen in 4; awsize in 3; awburst in 2.
- wvalid/wready  in/out  1; wid in ID_WIDTH; wdata in 32; wstrb in 4; wlast in 1.
- bvalid/bready  out/in  1; bid out ID_WIDTH; bresp out 2.
- arvalid/arready  in/out  1; arid in ID_WIDTH; araddr in ADDR_WIDTH; arlen in 4; arsize in 3; arburst in 2.
- rvalid/rready  out/in  1; rid out ID_WIDTH; rdata out 32; rstrb out 4 (constant 4'hF); rlast out 1; rresp out 2.

## Operation
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. An AW handshake latches id, addr, len, size and burst, clears the beat counter, and moves to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the wdata bytes selected by wstrb to word addr[log2(MEM_WORDS)+1:2], then advances the address and the counter. The beat with counter==len moves the FSM to W_RESP.
  - W_RESP: bvalid=1 and bid=latched id, held until bready. The B handshake returns to W_IDLE.
- Write error: bresp=SLVERR (2'b10) if any beat has wid!=latched id, wlast=1 before the final beat, or wlast=0 on the final beat. Data is still written. Termination always follows the beat count.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. An AR handshake latches the burst and loads rdata from the start address.
  - R_DATA: rvalid=1, rid=latched id, rlast=(counter==arlen). On each R handshake the address advances and rdata reloads. The last handshake returns to R_IDLE.
- Address generation (8-bit step):
  - Step = 1<<size bytes; size>2 is clamped to 2.
  - FIXED (00): address unchanged.
  - INCR (01) and reserved (11): addr+step.
  - WRAP (10): boundary = (len+1)*step; next = (addr & ~(boundary-1)) | ((addr+step) & (boundary-1)). len is not 1/3/7/15 -> treated as INCR with resp SLVERR.
- Same-cycle write and read of one word: rdata returns the old contents.
- Write and read channels proceed fully concurrently.

## Timing
- Reset values: awready=0, arready=0, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0. Memory contents are not reset.
- awready and arready go to 1 on the first clk edge after resetn deasserts.
- All outputs are registered.
- AW handshake at edge N: wready=1 from N+1. Final W handshake at M: bvalid=1 from M+1, wready=0 from M+1.
- AR handshake at N: rvalid=1 with the first beat from N+1. The next beat follows one cycle after each rready handshake, so zero-wait streaming gives one beat per cycle.
- rvalid/rdata/rlast are stable while rready=0. bvalid/bid/bresp are stable while bready=0.
- resetn asserted mid-burst: both FSMs return to idle immediately and the partial burst is discarded (already-written beats remain).

## Configuration
- AXI_SLV_DECERR_EN defined: a start address, or any beat address, with word index >= MEM_WORDS, or with nonzero bits above the memory range, gives the following. Writes to it are dropped and bresp=DECERR (2'b11); DECERR outranks SLVERR. Reads of it return rdata=0 and rresp=DECERR for that beat.
- AXI_SLV_DECERR_EN undefined: the address is used modulo the memory size and responses are OKAY apart from the SLVERR cases.

## Structure
- axi_pkg holds:
  - burst encodings BURST_FIXED/INCR/WRAP;
  - response encodings RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - wr_state_t and rd_state_t enums.
- Sub-module axi_addr_gen: combinational next address from (addr, size, len, burst) plus a wrap-len error flag. It is instantiated twice, once for write and once for read.

## Test plan
- INCR write: awaddr=0x10, awlen=3, awsize=2, data 0xA0..0xA3, wstrb=F. Required: bresp=OKAY, bid=awid. INCR read of the same range returns 0xA0..0xA3, rlast only on beat 4, rresp=OKAY.
- WRAP read: araddr=0x18, arlen=3, size=2. Required beat addresses 0x18, 0x1C, 0x10, 0x14.
- Byte strobe: write 0xFFFFFFFF to 0x40, then write 0x00000000 with wstrb=4'b0101. Required: reading 0x40 returns 0xFF00FF00.
- Backpressure: rready toggles every other cycle during an 8-beat read. Required: rdata is held while stalled, 8 beats total, no beat lost or duplicated. bready is held low 5 cycles; required: bvalid stays 1 with stable bresp.
- Protocol error: 4-beat write with wlast on beat 2 -> bresp=SLVERR, all 4 beats are written. With AXI_SLV_DECERR_EN, a write to word MEM_WORDS -> bresp=DECERR. Without the macro, the same write aliases to word 0.
- Reset mid-burst: assert resetn after 2 of 4 W beats. Required: all valid/ready outputs 0 during reset, then awready=1 one cycle after release, and a new burst completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI burst/response encodings and FSM state types
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA} rd_state_t;

  // WRAP is only legal for 2, 4, 8 or 16 beats
  function automatic logic wrap_len_bad(input logic [1:0] burst, input logic [3:0] len);
    return (burst == BURST_WRAP) &&
           !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
  endfunction

  function automatic logic [1:0] resp_code(input logic dec, input logic slv);
    return dec ? RESP_DECERR : (slv ? RESP_SLVERR : RESP_OKAY);
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// rtl/axi_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module axi_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [3:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  wrap_err
);

  logic [7:0]            step;
  logic [7:0]            bound;
  logic [ADDR_WIDTH-1:0] mask;
  logic [ADDR_WIDTH-1:0] incr;

  always_comb begin
    step      = (size > 3'd2) ? 8'd4 : (8'd1 << size);
    bound     = ({4'd0, len} + 8'd1) * step;
    mask      = {{(ADDR_WIDTH-8){1'b0}}, bound - 8'd1};
    incr      = addr + {{(ADDR_WIDTH-8){1'b0}}, step};
    wrap_err  = wrap_len_bad(burst, len);
    next_addr = incr;
    // an illegal WRAP length falls back to INCR stepping
    if (burst == BURST_FIXED)
      next_addr = addr;
    else if (burst == BURST_WRAP && !wrap_err)
      next_addr = (addr & ~mask) | (incr & mask);
  end

endmodule

// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - AXI3 memory responder; AXI_SLV_DECERR_EN enables out-of-range DECERR
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [3:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [ID_WIDTH-1:0]   wid,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wlast,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [3:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [31:0]           rdata,
  output logic [3:0]            rstrb,
  output logic                  rlast,
  output logic [1:0]            rresp
);

  localparam int IDXW = $clog2(MEM_WORDS);
`ifdef AXI_SLV_DECERR_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  // without decode errors the upper address bits simply alias
  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return DEC_EN && ((a >> (IDXW + 2)) != '0);
  endfunction

  logic [31:0] mem [MEM_WORDS];

  wr_state_t             w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr, w_next;
  logic [3:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_slv, w_dec, w_wrap_err;
  logic                  w_beat, w_final, w_beat_slv, w_beat_dec, mem_we;

  rd_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_addr, r_next;
  logic [3:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_wrap_err;

  assign rstrb = 4'hF;

  axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_gen (
    .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst),
    .next_addr(w_next), .wrap_err(w_wrap_err)
  );

  axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_gen (
    .addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst),
    .next_addr(r_next), .wrap_err(r_wrap_err)
  );

  assign w_beat     = (w_state == W_DATA) && wvalid && wready;
  assign w_final    = (w_cnt == w_len);
  assign w_beat_dec = out_of_range(w_addr);
  assign w_beat_slv = (wid != w_id) || (wlast != w_final) || w_wrap_err;
  assign mem_we     = w_beat && !w_beat_dec;

  always_ff @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[w_addr[IDXW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      bid     <= '0;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_slv   <= 1'b0;
      w_dec   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            w_id    <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_cnt   <= '0;
            w_slv   <= 1'b0;
            w_dec   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_addr <= w_next;
            w_cnt  <= w_cnt + 4'd1;
            w_slv  <= w_slv | w_beat_slv;
            w_dec  <= w_dec | w_beat_dec;
            // the beat count, not wlast, ends the burst
            if (w_final) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= w_id;
              bresp   <= resp_code(w_dec | w_beat_dec, w_slv | w_beat_slv);
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
      rid     <= '0;
      rdata   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
    end else if (r_state == R_IDLE) begin
      if (arvalid && arready) begin
        r_addr  <= araddr;
        r_len   <= arlen;
        r_size  <= arsize;
        r_burst <= arburst;
        r_cnt   <= '0;
        arready <= 1'b0;
        rvalid  <= 1'b1;
        rid     <= arid;
        rlast   <= (arlen == 4'd0);
        rdata   <= out_of_range(araddr) ? 32'd0 : mem[araddr[IDXW+1:2]];
        rresp   <= resp_code(out_of_range(araddr), wrap_len_bad(arburst, arlen));
        r_state <= R_DATA;
      end else begin
        arready <= 1'b1;
      end
    end else if (rready) begin
      if (r_cnt == r_len) begin
        rvalid  <= 1'b0;
        rlast   <= 1'b0;
        arready <= 1'b1;
        r_state <= R_IDLE;
      end else begin
        r_cnt  <= r_cnt + 4'd1;
        r_addr <= r_next;
        rlast  <= (r_cnt + 4'd1 == r_len);
        rdata  <= out_of_range(r_next) ? 32'd0 : mem[r_next[IDXW+1:2]];
        rresp  <= resp_code(out_of_range(r_next), r_wrap_err);
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb/tb_axi_slave_mem.sv - directed self-checking bench for axi_slave_mem
module tb_axi_slave_mem;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        awvalid = 0, awready;
  logic [3:0]  awid = 0;
  logic [31:0] awaddr = 0;
  logic [3:0]  awlen = 0;
  logic [2:0]  awsize = 0;
  logic [1:0]  awburst = 0;
  logic        wvalid = 0, wready;
  logic [3:0]  wid = 0;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        wlast = 0;
  logic        bvalid, bready = 0;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid = 0, arready;
  logic [3:0]  arid = 0;
  logic [31:0] araddr = 0;
  logic [3:0]  arlen = 0;
  logic [2:0]  arsize = 0;
  logic [1:0]  arburst = 0;
  logic        rvalid, rready = 0;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [3:0]  rstrb;
  logic        rlast;
  logic [1:0]  rresp;

  int errors = 0;
  int checks = 0;

  logic [31:0] wbuf [16];
  logic [3:0]  strb_v;
  logic [31:0] rbuf [16];
  logic [1:0]  rresp_buf [16];
  logic        rlast_buf [16];
  logic [3:0]  rid_buf [16];
  int          nbeats;
  int          holds_bad;
  int          bhold_bad;

  always #5 clk = ~clk;

  axi_slave_mem dut (
    .clk(clk), .resetn(resetn),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rstrb(rstrb),
    .rlast(rlast), .rresp(rresp)
  );

  task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input int last_at, input int bdelay,
                          output logic [1:0] resp, output logic [3:0] bid_o);
    int t;
    logic [1:0] r0;
    awvalid = 1; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awid = id;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin checks++; errors++; $display("FAIL aw_timeout awready=%b required=1", awready); end
    @(negedge clk);
    awvalid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      wvalid = 1; wdata = wbuf[b]; wstrb = strb_v; wid = id; wlast = (b == last_at);
      t = 0;
      while (!wready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin checks++; errors++; $display("FAIL w_timeout wready=%b required=1", wready); end
      @(negedge clk);
    end
    wvalid = 0; wlast = 0;
    t = 0;
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin checks++; errors++; $display("FAIL b_timeout bvalid=%b required=1", bvalid); end
    r0 = bresp;
    bhold_bad = 0;
    for (int i = 0; i < bdelay; i++) begin
      @(negedge clk);
      if (!bvalid || bresp !== r0) bhold_bad++;
    end
    resp = bresp; bid_o = bid;
    bready = 1;
    @(negedge clk);
    bready = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                         input logic [3:0] id, input bit toggle);
    int t;
    bit stalled;
    logic [31:0] pd;
    logic pl;
    arvalid = 1; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arid = id;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin checks++; errors++; $display("FAIL ar_timeout arready=%b required=1", arready); end
    @(negedge clk);
    arvalid = 0;
    nbeats = 0; holds_bad = 0; rready = !toggle; t = 0;
    while (nbeats <= int'(len) && t < 200) begin
      stalled = 0; pd = rdata; pl = rlast;
      if (rvalid && rready) begin
        rbuf[nbeats] = rdata; rresp_buf[nbeats] = rresp;
        rlast_buf[nbeats] = rlast; rid_buf[nbeats] = rid;
        nbeats++;
      end else if (rvalid) begin
        stalled = 1;
      end
      @(negedge clk);
      t++;
      if (stalled && (!rvalid || rdata !== pd || rlast !== pl)) holds_bad++;
      if (toggle) rready = !rready;
    end
    rready = 0;
    if (t >= 200) begin checks++; errors++; $display("FAIL r_timeout beats=%0d required=%0d", nbeats, int'(len) + 1); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b required=000000", {awready, arready, wready, bvalid, rvalid, rlast});
    end
    checks++;
    if ({bresp, rresp, bid, rid} !== 12'h0 || rdata !== 32'h0) begin
      errors++; $display("FAIL reset_data bresp=%h rresp=%h bid=%h rid=%h rdata=%h required=0", bresp, rresp, bid, rid, rdata);
    end
    resetn = 1;
    @(negedge clk);
    checks++;
    if ({awready, arready, wready} !== 3'b110) begin
      errors++; $display("FAIL reset_release got=%b required=110", {awready, arready, wready});
    end
  endtask

  task automatic test_incr();
    logic [1:0] resp;
    logic [3:0] b;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
    strb_v = 4'hF;
    do_write(32'h10, 4'd3, 2'b01, 4'd5, 3, 0, resp, b);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL incr_bresp got=%h required=0", resp); end
    checks++;
    if (b !== 4'd5) begin errors++; $display("FAIL incr_bid got=%h required=5", b); end
    do_read(32'h10, 4'd3, 2'b01, 4'd9, 0);
    checks++;
    if (nbeats !== 4) begin errors++; $display("FAIL incr_beats got=%0d required=4", nbeats); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rbuf[i] !== 32'hA0 + i || rlast_buf[i] !== (i == 3) || rresp_buf[i] !== 2'b00 || rid_buf[i] !== 4'd9) begin
        errors++;
        $display("FAIL incr_read beat=%0d data=%h last=%b resp=%h rid=%h required=%h %b 0 9",
                 i, rbuf[i], rlast_buf[i], rresp_buf[i], rid_buf[i], 32'hA0 + i, i == 3);
      end
    end
    checks++;
    if (rstrb !== 4'hF) begin errors++; $display("FAIL rstrb got=%h required=f", rstrb); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'hA2; exp_d[1] = 32'hA3; exp_d[2] = 32'hA0; exp_d[3] = 32'hA1;
    do_read(32'h18, 4'd3, 2'b10, 4'd2, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rbuf[i] !== exp_d[i] || rresp_buf[i] !== 2'b00) begin
        errors++; $display("FAIL wrap_read beat=%0d data=%h resp=%h required=%h 0", i, rbuf[i], rresp_buf[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    logic [3:0] b;
    wbuf[0] = 32'hFFFF_FFFF; strb_v = 4'hF;
    do_write(32'h40, 4'd0, 2'b01, 4'd1, 0, 0, resp, b);
    wbuf[0] = 32'h0; strb_v = 4'b0101;
    do_write(32'h40, 4'd0, 2'b01, 4'd1, 0, 0, resp, b);
    strb_v = 4'hF;
    do_read(32'h40, 4'd0, 2'b01, 4'd1, 0);
    checks++;
    if (rbuf[0] !== 32'hFF00_FF00) begin errors++; $display("FAIL strobe_read got=%h required=ff00ff00", rbuf[0]); end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp;
    logic [3:0] b;
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h1000 + i;
    strb_v = 4'hF;
    do_write(32'h100, 4'd7, 2'b01, 4'd3, 7, 0, resp, b);
    do_read(32'h100, 4'd7, 2'b01, 4'd3, 1);
    checks++;
    if (nbeats !== 8) begin errors++; $display("FAIL bp_beats got=%0d required=8", nbeats); end
    checks++;
    if (holds_bad !== 0) begin errors++; $display("FAIL bp_hold unstable_cycles=%0d required=0", holds_bad); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rbuf[i] !== 32'h1000 + i) begin errors++; $display("FAIL bp_data beat=%0d got=%h required=%h", i, rbuf[i], 32'h1000 + i); end
    end
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL bp_extra_beat rvalid=%b required=0", rvalid); end
    wbuf[0] = 32'h77;
    do_write(32'h140, 4'd0, 2'b01, 4'd6, 0, 5, resp, b);
    checks++;
    if (bhold_bad !== 0 || resp !== 2'b00) begin
      errors++; $display("FAIL b_hold unstable_cycles=%0d bresp=%h required=0 0", bhold_bad, resp);
    end
  endtask

  task automatic test_protocol_error();
    logic [1:0] resp;
    logic [3:0] b;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hE0 + i;
    strb_v = 4'hF;
    do_write(32'h200, 4'd3, 2'b01, 4'd4, 1, 0, resp, b);
    checks++;
    if (resp !== 2'b10) begin errors++; $display("FAIL early_wlast_bresp got=%h required=2", resp); end
    do_read(32'h200, 4'd3, 2'b01, 4'd4, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rbuf[i] !== 32'hE0 + i) begin errors++; $display("FAIL early_wlast_data beat=%0d got=%h required=%h", i, rbuf[i], 32'hE0 + i); end
    end
    do_read(32'h200, 4'd2, 2'b10, 4'd4, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rbuf[i] !== 32'hE0 + i || rresp_buf[i] !== 2'b10) begin
        errors++; $display("FAIL bad_wrap beat=%0d data=%h resp=%h required=%h 2", i, rbuf[i], rresp_buf[i], 32'hE0 + i);
      end
    end
    wbuf[0] = 32'hDEAD_BEEF;
    do_write(32'h1000, 4'd0, 2'b01, 4'd7, 0, 0, resp, b);
`ifdef AXI_SLV_DECERR_EN
    checks++;
    if (resp !== 2'b11) begin errors++; $display("FAIL decerr_bresp got=%h required=3", resp); end
    do_read(32'h1000, 4'd0, 2'b01, 4'd7, 0);
    checks++;
    if (rbuf[0] !== 32'h0 || rresp_buf[0] !== 2'b11) begin
      errors++; $display("FAIL decerr_read data=%h resp=%h required=0 3", rbuf[0], rresp_buf[0]);
    end
`else
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL alias_bresp got=%h required=0", resp); end
    do_read(32'h0, 4'd0, 2'b01, 4'd7, 0);
    checks++;
    if (rbuf[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alias_read got=%h required=deadbeef", rbuf[0]); end
`endif
  endtask

  task automatic test_reset_mid_burst();
    int t;
    logic [1:0] resp;
    logic [3:0] b;
    awvalid = 1; awaddr = 32'h300; awlen = 4'd3; awsize = 3'd2; awburst = 2'b01; awid = 4'd8;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    awvalid = 0;
    for (int i = 0; i < 2; i++) begin
      wvalid = 1; wdata = 32'h3A0 + i; wstrb = 4'hF; wid = 4'd8; wlast = 0;
      t = 0;
      while (!wready && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
    end
    wvalid = 0;
    resetn = 0;
    #1;
    checks++;
    if ({awready, arready, wready, bvalid, rvalid} !== 5'b0) begin
      errors++; $display("FAIL midrst_outputs got=%b required=00000", {awready, arready, wready, bvalid, rvalid});
    end
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    checks++;
    if ({awready, wready} !== 2'b10) begin errors++; $display("FAIL midrst_release got=%b required=10", {awready, wready}); end
    wbuf[0] = 32'h55; wbuf[1] = 32'h66; strb_v = 4'hF;
    do_write(32'h310, 4'd1, 2'b01, 4'd2, 1, 0, resp, b);
    checks++;
    if (resp !== 2'b00 || b !== 4'd2) begin errors++; $display("FAIL midrst_new_burst bresp=%h bid=%h required=0 2", resp, b); end
    do_read(32'h300, 4'd1, 2'b01, 4'd0, 0);
    checks++;
    if (rbuf[0] !== 32'h3A0 || rbuf[1] !== 32'h3A1) begin
      errors++; $display("FAIL midrst_partial got=%h %h required=3a0 3a1", rbuf[0], rbuf[1]);
    end
    do_read(32'h310, 4'd1, 2'b01, 4'd0, 0);
    checks++;
    if (rbuf[0] !== 32'h55 || rbuf[1] !== 32'h66) begin
      errors++; $display("FAIL midrst_new_data got=%h %h required=55 66", rbuf[0], rbuf[1]);
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_strobe();
    test_backpressure();
    test_protocol_error();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
